// File: rtl/apa102_pkg.sv
// rtl/apa102_pkg.sv - shared state encoding and frame constants for the APA102 output block
package apa102_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_FRAME,
      FETCH,
      SHIFT,
      END_FRAME
   } state_t;

   localparam int START_FRAME_BITS = 32;
   localparam int WORD_BITS        = 16;
   localparam int PIXEL_BITS       = 2 * WORD_BITS;

endpackage

// File: rtl/apa102_bit_serializer.sv
// rtl/apa102_bit_serializer.sv - APA102 bit timing: 2^(div+1)-cycle bit period, clock low then high
module apa102_bit_serializer (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] clock_divisor,
   input  logic       bit_tvalid,
   input  logic       bit_tdata,
   output logic       bit_tready,
   output logic       data_out,
   output logic       clock_out
);

   logic       busy;
   logic [3:0] cnt;
   logic [3:0] half;
   logic [3:0] last;

   assign half = 4'd1 << clock_divisor;
   // 2 << 3 wraps to 0 in four bits, so last still lands on 15 for the slowest rate
   assign last = (4'd2 << clock_divisor) - 4'd1;

   assign bit_tready = !busy || (cnt == last);

   // data_out only moves when a new bit is accepted, which is always the start of a low phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy      <= 1'b0;
         cnt       <= 4'd0;
         data_out  <= 1'b0;
         clock_out <= 1'b0;
      end else if (busy && (cnt != last)) begin
         cnt       <= cnt + 4'd1;
         clock_out <= ((cnt + 4'd1) >= half);
      end else if (bit_tvalid) begin
         busy      <= 1'b1;
         cnt       <= 4'd0;
         data_out  <= bit_tdata;
         clock_out <= 1'b0;
      end else begin
         busy      <= 1'b0;
         clock_out <= 1'b0;
      end
   end

endmodule

// File: rtl/apa102_out.sv
// rtl/apa102_out.sv - APA102 LED frame sender fetching pixels from a paged word memory
// Double-pixel output is compiled in only when APA102_DOUBLE_PIXEL_EN is defined.
module apa102_out
   import apa102_pkg::*;
#(
   parameter int ADDRESS_BUS_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
   input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
   input  logic [1:0]                   clock_divisor,
   input  logic [7:0]                   page_count,
   input  logic                         double_pixel,
   input  logic                         start_toggle,
   output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
   output logic                         read_request,
   input  logic [15:0]                  read_data,
   input  logic                         read_finished_strobe,
   output logic                         data_out,
   output logic                         clock_out
);

   localparam int AW = ADDRESS_BUS_WIDTH;
   localparam int PW = AW - 1;
   localparam int BW = AW + 1;

   state_t          state, state_nx;
   logic            toggle_q, pending;
   logic [PW-1:0]   npix_q, pix_idx;
   logic [AW-1:0]   page_base;
   logic [1:0]      div_q;
   logic [7:0]      pcount_q, page_index;
   logic            dbl_q, dbl_in;
   logic [BW-1:0]   bits_left, end_bits;
   logic            word_sel, repeat_q;
   logic [PIXEL_BITS-1:0] pixel;
   logic [4:0]      bit_pos;
   logic [AW+7:0]   page_offset;
   logic            bit_tvalid, bit_tdata, bit_tready, bit_fire;
   logic            last_bit, last_pixel, word_done;

`ifdef APA102_DOUBLE_PIXEL_EN
   assign dbl_in = double_pixel;
`else
   logic unused_double_pixel;
   assign unused_double_pixel = double_pixel;
   assign dbl_in = 1'b0;
`endif

   assign page_offset = {{AW{1'b0}}, page_index} * {8'd0, word_count};
   assign end_bits    = BW'(START_FRAME_BITS) +
                        (dbl_q ? {2'b00, npix_q} : {3'b000, npix_q[PW-1:1]});
   // bits_left of 32 maps to index 31 through the five-bit wrap
   assign bit_pos     = bits_left[4:0] - 5'd1;
   assign last_bit    = (bits_left == BW'(1));
   assign last_pixel  = (pix_idx == npix_q - PW'(1));
   assign word_done   = (state == FETCH) && read_request && read_finished_strobe;
   assign bit_fire    = bit_tvalid && bit_tready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:        if (pending) state_nx = START_FRAME;
         START_FRAME: if (bit_fire && last_bit)
                         state_nx = (npix_q == '0) ? END_FRAME : FETCH;
         FETCH:       if (word_done && word_sel) state_nx = SHIFT;
         SHIFT:       if (bit_fire && last_bit && !(dbl_q && !repeat_q))
                         state_nx = last_pixel ? END_FRAME : FETCH;
         END_FRAME:   if (bit_fire && last_bit) state_nx = IDLE;
         default:     state_nx = IDLE;
      endcase
   end

   always_comb begin
      bit_tvalid = 1'b0;
      bit_tdata  = 1'b0;
      case (state)
         START_FRAME: bit_tvalid = 1'b1;
         SHIFT: begin
            bit_tvalid = 1'b1;
            bit_tdata  = pixel[bit_pos];
         end
         END_FRAME: begin
            bit_tvalid = 1'b1;
            bit_tdata  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         toggle_q     <= 1'b0;
         pending      <= 1'b0;
         npix_q       <= '0;
         pix_idx      <= '0;
         page_base    <= '0;
         div_q        <= 2'd0;
         pcount_q     <= 8'd0;
         page_index   <= 8'd0;
         dbl_q        <= 1'b0;
         bits_left    <= '0;
         word_sel     <= 1'b0;
         repeat_q     <= 1'b0;
         pixel        <= '0;
         read_request <= 1'b0;
         read_address <= '0;
      end else begin
         toggle_q <= start_toggle;
         // a toggle landing on the service cycle keeps the flag set for the next frame
         if (start_toggle != toggle_q)     pending <= 1'b1;
         else if (state == IDLE && pending) pending <= 1'b0;

         case (state)
            IDLE: if (pending) begin
               npix_q    <= word_count[AW-1:1];
               page_base <= start_address + page_offset[AW-1:0];
               div_q     <= clock_divisor;
               pcount_q  <= page_count;
               dbl_q     <= dbl_in;
               bits_left <= BW'(START_FRAME_BITS);
               pix_idx   <= '0;
               word_sel  <= 1'b0;
               repeat_q  <= 1'b0;
            end
            START_FRAME: if (bit_fire)
               bits_left <= last_bit ? end_bits : bits_left - BW'(1);
            FETCH: begin
               if (!read_request) begin
                  read_request <= 1'b1;
                  read_address <= page_base + {pix_idx, word_sel};
               end else if (read_finished_strobe) begin
                  read_request <= 1'b0;
                  word_sel     <= !word_sel;
                  if (word_sel) begin
                     pixel[WORD_BITS-1:0] <= read_data;
                     bits_left            <= BW'(PIXEL_BITS);
                  end else begin
                     pixel[PIXEL_BITS-1:WORD_BITS] <= read_data;
                  end
               end
            end
            SHIFT: if (bit_fire) begin
               if (!last_bit) begin
                  bits_left <= bits_left - BW'(1);
               end else if (dbl_q && !repeat_q) begin
                  repeat_q  <= 1'b1;
                  bits_left <= BW'(PIXEL_BITS);
               end else begin
                  repeat_q  <= 1'b0;
                  pix_idx   <= pix_idx + PW'(1);
                  bits_left <= end_bits;
               end
            end
            END_FRAME: if (bit_fire) begin
               if (!last_bit)
                  bits_left <= bits_left - BW'(1);
               // page_count of 0 or 1 always satisfies the wrap test
               else if (page_index + 8'd1 >= pcount_q)
                  page_index <= 8'd0;
               else
                  page_index <= page_index + 8'd1;
            end
            default: ;
         endcase
      end
   end

   apa102_bit_serializer u_serializer (
      .clk           (clk),
      .rst           (rst),
      .clock_divisor (div_q),
      .bit_tvalid    (bit_tvalid),
      .bit_tdata     (bit_tdata),
      .bit_tready    (bit_tready),
      .data_out      (data_out),
      .clock_out     (clock_out)
   );

endmodule

// File: tb/tb_apa102_out.sv
// tb/tb_apa102_out.sv - scoreboard bench for apa102_out serial frames and memory reads
module tb_apa102_out;

   typedef struct {
      logic b;
      int   per;
      logic stretch;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] word_count = 16'd0;
   logic [15:0] start_address = 16'd0;
   logic [1:0]  clock_divisor = 2'd0;
   logic [7:0]  page_count = 8'd1;
   logic        double_pixel = 1'b0;
   logic        start_toggle = 1'b0;
   logic [15:0] read_address;
   logic        read_request;
   logic [15:0] read_data = 16'd0;
   logic        read_finished_strobe = 1'b0;
   logic        data_out;
   logic        clock_out;

   logic [15:0] mem [0:1023];
   int          mem_delay = 0;
   int          exp_half = 1;
   int          checks = 0;
   int          failures = 0;
   int          extra_bits = 0;
   exp_t        exp_bits[$];
   logic [15:0] exp_addr[$];

   always #5 clk = ~clk;

   apa102_out #(.ADDRESS_BUS_WIDTH(16)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .word_count           (word_count),
      .start_address        (start_address),
      .clock_divisor        (clock_divisor),
      .page_count           (page_count),
      .double_pixel         (double_pixel),
      .start_toggle         (start_toggle),
      .read_address         (read_address),
      .read_request         (read_request),
      .read_data            (read_data),
      .read_finished_strobe (read_finished_strobe),
      .data_out             (data_out),
      .clock_out            (clock_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_run(input logic b, input int n, input int per);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.b = b;
         e.per = (i == 0) ? 0 : per;
         e.stretch = 1'b0;
         exp_bits.push_back(e);
      end
   endtask

   task automatic push_word(input logic [15:0] w, input logic stretch_first);
      exp_t e;
      for (int i = 15; i >= 0; i--) begin
         e.b = w[i];
         e.per = 0;
         e.stretch = (i == 15) ? stretch_first : 1'b0;
         exp_bits.push_back(e);
      end
   endtask

   task automatic toggle();
      @(posedge clk);
      #1 start_toggle = ~start_toggle;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      start_toggle = 1'b0;
      exp_bits.delete();
      exp_addr.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget, input int tail);
      int n = 0;
      while ((exp_bits.size() != 0 || exp_addr.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(name, exp_bits.size() + exp_addr.size(), 0);
      repeat (tail) @(posedge clk);
   endtask

   // memory: answers each request after mem_delay cycles with a one-cycle strobe
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (read_request) begin
            repeat (mem_delay) begin
               @(posedge clk);
               #1;
            end
            read_data = mem[read_address[9:0]];
            read_finished_strobe = 1'b1;
            @(posedge clk);
            #1 read_finished_strobe = 1'b0;
         end
      end
   end

   // serial monitor: pops one expected bit per clock_out rising edge
   initial begin
      logic prev_clk = 1'b0;
      logic prev_data = 1'b0;
      int   since_rise = 0;
      int   high_cnt = 0;
      int   low_cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_clk = 1'b0;
            prev_data = 1'b0;
            since_rise = 0;
            high_cnt = 0;
            low_cnt = 0;
         end else begin
            since_rise++;
            if (clock_out && !prev_clk) begin
               check("data_stable_at_rise", data_out, prev_data);
               if (exp_bits.size() == 0) begin
                  checks++;
                  failures++;
                  extra_bits++;
                  $display("FAIL unexpected_bit actual=%0b expected=none at %0t", data_out, $time);
               end else begin
                  e = exp_bits.pop_front();
                  check("serial_bit", data_out, e.b);
                  if (e.per != 0) check("bit_period", since_rise, e.per);
                  if (e.stretch) check("stall_low_stretched", low_cnt > exp_half, 1);
               end
               since_rise = 0;
            end
            if (!clock_out && prev_clk) check("high_phase", high_cnt, exp_half);
            if (clock_out) begin
               high_cnt++;
               low_cnt = 0;
            end else begin
               high_cnt = 0;
               low_cnt++;
            end
            prev_clk = clock_out;
            prev_data = data_out;
         end
      end
   end

   // read monitor: checks each completed read address in order
   initial begin
      forever begin
         @(negedge clk);
         if (rst && read_request && read_finished_strobe) begin
            if (exp_addr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_read actual=%0h expected=none", read_address);
            end else begin
               check("read_address", read_address, exp_addr.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [15:0] pg_w0 [4];
      logic [15:0] pg_w1 [4];
      logic [15:0] pg_a [4];
      int n;
      int bad;

      for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
      mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h8001; mem[3] = 16'h7FFE;
      mem[10'h100] = 16'hC3A5; mem[10'h101] = 16'h0F0F;
      mem[10'h102] = 16'h8421; mem[10'h103] = 16'h1248;
      mem[10'h104] = 16'hFFFF; mem[10'h105] = 16'h0000;
      mem[10'h200] = 16'hE1FF; mem[10'h201] = 16'h0000;
      mem[10'h010] = 16'h9C3E; mem[10'h011] = 16'h0001;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset_data_out", data_out, 0);
      check("reset_clock_out", clock_out, 0);
      check("reset_read_request", read_request, 0);
      check("reset_read_address", read_address, 0);
      rst = 1'b1;

      // four words, fastest rate
      word_count = 16'd4; start_address = 16'h0000; clock_divisor = 2'd0;
      page_count = 8'd1; double_pixel = 1'b0; mem_delay = 0; exp_half = 1;
      push_run(1'b0, 32, 2);
      push_word(16'h1234, 1'b0); push_word(16'hABCD, 1'b0);
      push_word(16'h8001, 1'b0); push_word(16'h7FFE, 1'b0);
      push_run(1'b1, 33, 0);
      exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0001);
      exp_addr.push_back(16'h0002); exp_addr.push_back(16'h0003);
      toggle();
      wait_drain("frame_basic", 5000, 10);

      // page stepping and wrap with three pages
      do_reset();
      word_count = 16'd2; start_address = 16'h0100; page_count = 8'd3;
      pg_w0 = '{16'hC3A5, 16'h8421, 16'hFFFF, 16'hC3A5};
      pg_w1 = '{16'h0F0F, 16'h1248, 16'h0000, 16'h0F0F};
      pg_a  = '{16'h0100, 16'h0102, 16'h0104, 16'h0100};
      for (int p = 0; p < 4; p++) begin
         push_run(1'b0, 32, 2);
         push_word(pg_w0[p], 1'b0); push_word(pg_w1[p], 1'b0);
         push_run(1'b1, 32, 0);
         exp_addr.push_back(pg_a[p]); exp_addr.push_back(pg_a[p] + 16'd1);
         toggle();
         wait_drain("frame_page", 3000, 10);
      end

      // double pixel
      do_reset();
      word_count = 16'd2; start_address = 16'h0200; page_count = 8'd1; double_pixel = 1'b1;
      push_run(1'b0, 32, 2);
      push_word(16'hE1FF, 1'b0); push_word(16'h0000, 1'b0);
`ifdef APA102_DOUBLE_PIXEL_EN
      push_word(16'hE1FF, 1'b0); push_word(16'h0000, 1'b0);
      push_run(1'b1, 33, 0);
`else
      push_run(1'b1, 32, 0);
`endif
      exp_addr.push_back(16'h0200); exp_addr.push_back(16'h0201);
      toggle();
      wait_drain("frame_double", 3000, 10);

      // slowest rate with a slow bus
      do_reset();
      double_pixel = 1'b0; clock_divisor = 2'd3; exp_half = 8; mem_delay = 10;
      word_count = 16'd2; start_address = 16'h0010; page_count = 8'd1;
      push_run(1'b0, 32, 16);
      push_word(16'h9C3E, 1'b1); push_word(16'h0001, 1'b0);
      push_run(1'b1, 32, 0);
      exp_addr.push_back(16'h0010); exp_addr.push_back(16'h0011);
      toggle();
      wait_drain("frame_slow", 20000, 40);

      // two toggles inside a frame give exactly one follow-up frame
      do_reset();
      clock_divisor = 2'd1; exp_half = 2; mem_delay = 10;
      word_count = 16'd4; start_address = 16'h0000; page_count = 8'd1;
      for (int f = 0; f < 2; f++) begin
         push_run(1'b0, 32, 4);
         push_word(16'h1234, 1'b0); push_word(16'hABCD, 1'b0);
         push_word(16'h8001, 1'b0); push_word(16'h7FFE, 1'b0);
         push_run(1'b1, 33, 0);
         for (int a = 0; a < 4; a++) exp_addr.push_back(16'(a));
      end
      extra_bits = 0;
      toggle();
      repeat (40) @(posedge clk);
      toggle();
      repeat (10) @(posedge clk);
      toggle();
      wait_drain("frame_pair", 20000, 400);
      check("no_extra_frame", extra_bits, 0);

      // reset in the middle of a fetch
      push_run(1'b0, 32, 4);
      push_word(16'h1234, 1'b0); push_word(16'hABCD, 1'b0);
      push_word(16'h8001, 1'b0); push_word(16'h7FFE, 1'b0);
      push_run(1'b1, 33, 0);
      for (int a = 0; a < 4; a++) exp_addr.push_back(16'(a));
      toggle();
      n = 0;
      while (exp_bits.size() > 65 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      while (!read_request && n < 5100) begin
         @(posedge clk);
         n++;
      end
      check("mid_frame_fetch_reached", read_request, 1);
      @(posedge clk);
      #2;
      check("data_before_reset", data_out, 1);
      rst = 1'b0;
      start_toggle = 1'b0;
      #1;
      check("abort_data_out", data_out, 0);
      check("abort_clock_out", clock_out, 0);
      check("abort_read_request", read_request, 0);
      check("abort_read_address", read_address, 0);
      exp_bits.delete();
      exp_addr.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (read_request || clock_out) bad++;
      end
      check("idle_after_abort", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
